div_unit: RTL and testbench

Multi-cycle radix-2 restoring divider for the EX stage, handling DIV/DIVU. EX asserts start while it holds a stall request. The unit returns the quotient for LO and the remainder for HI. It is a parametrised replacement for single-width division, adding divide-by-zero and zero-dividend early exits and a flush-driven annul.

---
 rtl/div_unit.sv | 166 ++++++++++++++++
 tb/tb_div_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle radix-2 restoring divider (DIV/DIVU) returning
//                quotient for LO and remainder for HI, with divide-by-zero,
//                zero-dividend early exit and flush-driven annul.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH      = 32,
    parameter int EARLY_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             div_zero_o
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_DIVZERO = 2'd1;
    localparam logic [1:0] c_ON      = 2'd2;
    localparam logic [1:0] c_END     = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_remd;
    logic               r_div_zero;

    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic               w_zero_exit;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Magnitudes; the most negative value maps onto its own unsigned bit pattern.
    assign w_dvd_neg = signed_i & dividend_i[WIDTH-1];
    assign w_dvs_neg = signed_i & divisor_i[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? ({WIDTH{1'b0}} - dividend_i) : dividend_i;
    assign w_dvs_mag = w_dvs_neg ? ({WIDTH{1'b0}} - divisor_i) : divisor_i;

    generate
        if (EARLY_ZERO != 0) begin : g_early_zero
            assign w_zero_exit = (dividend_i == {WIDTH{1'b0}});
        end else begin : g_no_early_zero
            assign w_zero_exit = 1'b0;
        end
    endgenerate

    // r_dvd shifts dividend bits out at the top while quotient bits enter at the bottom.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_quo_fix  = r_neg_q ? ({WIDTH{1'b0}} - w_quo_next) : w_quo_next;
    assign w_rem_fix  = r_neg_r ? ({WIDTH{1'b0}} - w_rem_next) : w_rem_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_quot     <= '0;
            r_remd     <= '0;
            r_div_zero <= 1'b0;
        end else if (annul_i) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_quot     <= '0;
            r_remd     <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        r_count <= '0;
                        r_rem   <= '0;
                        r_dvd   <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_quot  <= '0;
                        r_remd  <= '0;
                        if (divisor_i == {WIDTH{1'b0}}) begin
                            r_state <= c_DIVZERO;
                        end else if (w_zero_exit) begin
                            r_state <= c_END;
                        end else begin
                            r_state <= c_ON;
                        end
                    end
                end
                c_DIVZERO: begin
                    r_state    <= c_END;
                    r_quot     <= '0;
                    r_remd     <= '0;
                    r_div_zero <= 1'b1;
                end
                c_ON: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_quo_next;
                    if (r_count == c_LAST) begin
                        r_state <= c_END;
                        r_quot  <= w_quo_fix;
                        r_remd  <= w_rem_fix;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_END: begin
                    if (!start_i) begin
                        r_state    <= c_IDLE;
                        r_count    <= '0;
                        r_quot     <= '0;
                        r_remd     <= '0;
                        r_div_zero <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign quotient_o  = r_quot;
    assign remainder_o = r_remd;
    assign div_zero_o  = r_div_zero;
    assign ready_o     = (r_state == c_END);
    assign busy_o      = (r_state == c_DIVZERO) || (r_state == c_ON);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// Testbench for div_unit: table vectors, randomized ops against an arithmetic
// reference model, and hand sequences for annul and asynchronous reset.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic         annul = 1'b0;
    logic [W-1:0] dvd = '0;
    logic [W-1:0] dvs = '0;

    logic [W-1:0] q_a, r_a, q_b, r_b;
    logic         rdy_a, busy_a, dz_a;
    logic         rdy_b, busy_b, dz_b;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W), .EARLY_ZERO(1)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
        .dividend_i(dvd), .divisor_i(dvs), .annul_i(annul),
        .quotient_o(q_a), .remainder_o(r_a), .ready_o(rdy_a),
        .busy_o(busy_a), .div_zero_o(dz_a)
    );

    div_unit #(.WIDTH(W), .EARLY_ZERO(0)) u_dut_nez (
        .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
        .dividend_i(dvd), .divisor_i(dvs), .annul_i(annul),
        .quotient_o(q_b), .remainder_o(r_b), .ready_o(rdy_b),
        .busy_o(busy_b), .div_zero_o(dz_b)
    );

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb;
        longint unsigned ua, ub;
        dz = (b == '0);
        q  = '0;
        r  = '0;
        if (!dz) begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = W'(sa / sb);
                r  = W'(sa % sb);
            end else begin
                ua = longint'(a);
                ub = longint'(b);
                q  = W'(ua / ub);
                r  = W'(ua % ub);
            end
        end
    endfunction

    task automatic do_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int lat_a, lat_b, busy_cnt, exp_lat_a, exp_lat_b;
        lat_a = 0; lat_b = 0; busy_cnt = 0;
        exp_lat_b = (b == '0) ? 2 : W + 1;
        exp_lat_a = (b == '0) ? 2 : ((a == '0) ? 1 : W + 1);
        @(negedge clk);
        start = 1'b1; sgn = s; dvd = a; dvs = b;
        for (int e = 1; e <= W + 10 && (lat_a == 0 || lat_b == 0); e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 1) begin
                dvd = $urandom; dvs = $urandom; sgn = ~sgn;
            end
            if (busy_a) busy_cnt++;
            if (rdy_a && lat_a == 0) lat_a = e;
            if (rdy_b && lat_b == 0) lat_b = e;
        end
        check({tag, " latency"}, lat_a, exp_lat_a);
        check({tag, " latency_nez"}, lat_b, exp_lat_b);
        check({tag, " busy_cycles"}, busy_cnt, exp_lat_a - 1);
        check({tag, " quotient"}, q_a, eq);
        check({tag, " remainder"}, r_a, er);
        check({tag, " div_zero"}, dz_a, edz);
        check({tag, " quotient_nez"}, q_b, eq);
        check({tag, " remainder_nez"}, r_b, er);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " ready_drop"}, {rdy_a, rdy_b, dz_a}, 3'b000);
        check({tag, " result_clear"}, {q_a, r_a}, 64'd0);
    endtask

    vec_t tbl[14];

    initial begin
        logic [W-1:0] ra, rb, mq, mr;
        logic         rs, mdz;
        int           seen;

        tbl[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0};
        tbl[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF, 32'd1,        1'b0};
        tbl[4]  = '{1'b0, 32'h0000_1234,  32'd0,        32'd0,        32'd0,        1'b1};
        tbl[5]  = '{1'b1, 32'h0000_1234,  32'd0,        32'd0,        32'd0,        1'b1};
        tbl[6]  = '{1'b0, 32'd0,          32'd5,        32'd0,        32'd0,        1'b0};
        tbl[7]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0};
        tbl[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
        tbl[9]  = '{1'b1, 32'd0,          32'hFFFF_FFFB, 32'd0,        32'd0,        1'b0};
        tbl[10] = '{1'b0, 32'd9,          32'd3,        32'd3,        32'd0,        1'b0};
        tbl[11] = '{1'b1, 32'h8000_0000,  32'd1,        32'h8000_0000, 32'd0,        1'b0};
        tbl[12] = '{1'b0, 32'd5,          32'd5,        32'd1,        32'd0,        1'b0};
        tbl[13] = '{1'b0, 32'd3,          32'd7,        32'd0,        32'd3,        1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset outputs", {q_a, r_a, rdy_a, busy_a, dz_a}, 67'd0);
        check("reset outputs_nez", {q_b, r_b, rdy_b, busy_b, dz_b}, 67'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);
        end

        for (int k = 0; k < 40; k++) begin
            rs = 1'(($urandom_range(0, 1)));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: ra = '0;
                2: rb = W'($urandom_range(1, 15));
                3: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : rb; end
                default: ;
            endcase
            model(rs, ra, rb, mq, mr, mdz);
            do_op($sformatf("rnd%0d", k), rs, ra, rb, mq, mr, mdz);
        end

        // Annul at ON cycle 10: abort, ready never rises
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dvd = 32'd100; dvs = 32'd7;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("annul pre busy", busy_a, 1'b1);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        check("annul idle", {busy_a, rdy_a, busy_b, rdy_b}, 4'b0000);
        seen = 0;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge clk);
            if (rdy_a || rdy_b || busy_a) seen++;
        end
        check("annul no ready", seen, 0);
        do_op("after_annul 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Annul has priority over start in IDLE
        @(negedge clk);
        start = 1'b1; annul = 1'b1; dvd = 32'd9; dvs = 32'd3;
        @(posedge clk);
        @(negedge clk);
        check("annul over start", {busy_a, rdy_a}, 2'b00);
        start = 1'b0; annul = 1'b0;

        // Annul has priority over completion on the final step
        @(negedge clk);
        start = 1'b1; dvd = 32'd100; dvs = 32'd7;
        repeat (W) @(posedge clk);
        @(negedge clk);
        check("final step busy", {busy_a, rdy_a}, 2'b10);
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("annul over completion", {rdy_a, busy_a, q_a}, 34'd0);
        annul = 1'b0; start = 1'b0;

        // Annul in END while start held
        @(negedge clk);
        start = 1'b1; dvd = 32'd9; dvs = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("divzero end", {rdy_a, dz_a}, 2'b11);
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("annul in end", {rdy_a, dz_a}, 2'b00);
        annul = 1'b0; start = 1'b0;

        // Asynchronous reset while holding a result
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dvd = 32'd100; dvs = 32'd7;
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        check("pre-reset result", {rdy_a, q_a, r_a}, {1'b1, 32'd14, 32'd2});
        #2 rst = 1'b0;
        #1 check("async reset end", {q_a, r_a, rdy_a, busy_a, dz_a}, 67'd0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-ON
        start = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("mid-on busy", busy_a, 1'b1);
        #2 rst = 1'b0;
        #1 check("async reset on", {q_a, r_a, rdy_a, busy_a, dz_a}, 67'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post reset idle", {busy_a, rdy_a}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
